// File: rtl/enc_acq_pkg.sv
// Shared types and defaults for the encoder acquisition blocks.
package enc_acq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TRIG    = 3'd1,
        ST_WAIT_HI = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_READ    = 3'd4,
        ST_PUBLISH = 3'd5
    } acq_state_t;

    localparam int TRIG_W_DEF      = 4;
    localparam int READ_CYCLES_DEF = 34;
    localparam int TIMEOUT_DEF     = 1023;

    // Counters up to 32 bits wide: pass the value and its ceiling zero-extended.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/enc_busy_sync.sv
// Two-flop synchroniser for an asynchronous level, with one-cycle edge pulses.
module enc_busy_sync (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta, sync, prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= pin;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~prev;
    assign fall  = ~sync & prev;

endmodule

// File: rtl/enc_acq_scheduler.sv
// Periodic trigger, busy-handshake supervision and frame publication for the
// 16-channel encoder ADC acquisition core.
module enc_acq_scheduler
    import enc_acq_pkg::*;
#(
    parameter int PERIOD_W    = 16,
    parameter int TRIG_W      = TRIG_W_DEF,
    parameter int READ_CYCLES = READ_CYCLES_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    input  logic                busy,
    input  logic                clr_err,
    input  logic                frame_ack,
    output logic                trig_out,
    output logic                snap_stb,
    output logic                frame_valid,
    output logic [CNT_W-1:0]    frame_seq,
    output logic [CNT_W-1:0]    overrun_cnt,
    output logic [CNT_W-1:0]    timeout_cnt,
    output logic                err_timeout,
    output logic                err_lost,
    output logic [2:0]          state_o
);

    localparam int CMAX0 = (TIMEOUT > READ_CYCLES) ? TIMEOUT : READ_CYCLES;
    localparam int CMAX  = (CMAX0 > TRIG_W) ? CMAX0 : TRIG_W;
    localparam int TW    = $clog2(CMAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic busy_lvl, busy_fall, busy_rise_unused;

    enc_busy_sync u_busy_sync (
        .clk   (clk),
        .rst   (rst),
        .pin   (busy),
        .level (busy_lvl),
        .rise  (busy_rise_unused),
        .fall  (busy_fall)
    );

    // The period in force is taken from the input in the first cycle of each
    // period and held for the rest of it, so a change applies from the next wrap.
    logic [PERIOD_W-1:0] pcnt, plen_q, plen;
    logic                tick;

    always_comb begin
        plen = (pcnt == '0) ? period : plen_q;
        tick = enable && ((plen <= PERIOD_W'(1)) || (pcnt >= plen - PERIOD_W'(1)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt   <= '0;
            plen_q <= '0;
        end else if (!enable) begin
            pcnt <= '0;
        end else begin
            if (pcnt == '0)
                plen_q <= period;
            pcnt <= tick ? '0 : pcnt + PERIOD_W'(1);
        end
    end

    // One counter serves the trigger width, the wait watchdog and the readout delay.
    acq_state_t    state;
    logic [TW-1:0] cnt;
    logic          tmo_hit, abort, publish;

    assign tmo_hit = (cnt == TW'(TIMEOUT - 1));
    assign abort   = ((state == ST_WAIT_HI) && !busy_lvl && tmo_hit) ||
                     ((state == ST_WAIT_LO) && !busy_fall && tmo_hit);
    assign publish = (state == ST_PUBLISH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: if (tick) begin
                    state <= ST_TRIG;
                    cnt   <= TW'(TRIG_W - 1);
                end
                ST_TRIG: if (cnt == '0) begin
                    state <= ST_WAIT_HI;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt - TW'(1);
                end
                ST_WAIT_HI: if (busy_lvl) begin
                    state <= ST_WAIT_LO;
                    cnt   <= '0;
                end else if (tmo_hit) begin
                    state <= ST_IDLE;
                end else begin
                    cnt <= cnt + TW'(1);
                end
                ST_WAIT_LO: if (busy_fall) begin
                    state <= ST_READ;
                    cnt   <= TW'(READ_CYCLES);
                end else if (tmo_hit) begin
                    state <= ST_IDLE;
                end else begin
                    cnt <= cnt + TW'(1);
                end
                ST_READ: begin
                    cnt <= cnt - TW'(1);
                    if (cnt == TW'(1))
                        state <= ST_PUBLISH;
                end
                ST_PUBLISH: state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_seq   <= '0;
            frame_valid <= 1'b0;
            err_timeout <= 1'b0;
            err_lost    <= 1'b0;
            overrun_cnt <= '0;
            timeout_cnt <= '0;
        end else begin
            if (publish)
                frame_seq <= frame_seq + CNT_W'(1);
            // A publish with a same-cycle ack replaces the acked frame.
            if (publish)
                frame_valid <= 1'b1;
            else if (frame_ack)
                frame_valid <= 1'b0;
            if (clr_err) begin
                err_timeout <= 1'b0;
                err_lost    <= 1'b0;
                overrun_cnt <= '0;
                timeout_cnt <= '0;
            end else begin
                if (abort) begin
                    err_timeout <= 1'b1;
                    timeout_cnt <= CNT_W'(sat_inc(32'(timeout_cnt), 32'(CNT_MAX)));
                end
                if (publish && frame_valid && !frame_ack)
                    err_lost <= 1'b1;
                if (tick && (state != ST_IDLE))
                    overrun_cnt <= CNT_W'(sat_inc(32'(overrun_cnt), 32'(CNT_MAX)));
            end
        end
    end

    assign trig_out = (state == ST_TRIG);
    assign snap_stb = publish;
    assign state_o  = state;

endmodule

// File: tb/tb_enc_acq_scheduler.sv
// Directed bench for enc_acq_scheduler: timestamp-based reference model checked
// every cycle, plus hand-computed latencies and counter values.
module tb_enc_acq_scheduler;

    localparam int PERIOD_W = 16, TRIG_W = 4, READ_CYCLES = 34, TIMEOUT = 1023, CNT_W = 16;

    logic                clk = 1'b0, rst = 1'b1, enable = 1'b0, busy = 1'b0;
    logic                clr_err = 1'b0, frame_ack = 1'b0;
    logic [PERIOD_W-1:0] period = 16'd200;
    logic                trig_out, snap_stb, frame_valid, err_timeout, err_lost;
    logic [CNT_W-1:0]    frame_seq, overrun_cnt, timeout_cnt;
    logic [2:0]          state_o;

    int total = 0, bad = 0;
    int cyc = 0;
    bit adc_on = 1'b1;
    int fall_cyc = -1;

    enc_acq_scheduler #(
        .PERIOD_W(PERIOD_W), .TRIG_W(TRIG_W), .READ_CYCLES(READ_CYCLES),
        .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .period(period), .busy(busy),
        .clr_err(clr_err), .frame_ack(frame_ack), .trig_out(trig_out),
        .snap_stb(snap_stb), .frame_valid(frame_valid), .frame_seq(frame_seq),
        .overrun_cnt(overrun_cnt), .timeout_cnt(timeout_cnt),
        .err_timeout(err_timeout), .err_lost(err_lost), .state_o(state_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, exp);
        end
    endtask

    // ADC stand-in: busy rises 10 cycles after a trigger starts, falls 40 later.
    initial begin : adc
        bit prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (adc_on && trig_out && !prev) begin
                repeat (10) @(posedge clk);
                #1 busy = 1'b1;
                repeat (40) @(posedge clk);
                #1 busy = 1'b0;
                fall_cyc = cyc;
            end
            prev = trig_out;
        end
    end

    // Reference model: a frame is described by its start cycle and the cycles at
    // which busy-high and busy-fall were observed; the expected phase is derived
    // from those timestamps. Inputs of the current cycle then advance the model.
    initial begin : model
        int fs, hs, ls, ws, pstart, plen, off, lim, c, ph;
        int seq, ovr, tmo, eto, elo, fv;
        bit fr, tick, p1, p2, p3, s, fl;
        fr = 0; fs = 0; hs = -1; ls = -1; pstart = 0; plen = 0; off = 0;
        seq = 0; ovr = 0; tmo = 0; eto = 0; elo = 0; fv = 0;
        p1 = 0; p2 = 0; p3 = 0;
        forever begin
            @(negedge clk);
            c = cyc;
            if (rst) begin
                fr = 0; seq = 0; ovr = 0; tmo = 0; eto = 0; elo = 0; fv = 0;
                p1 = 0; p2 = 0; p3 = 0; pstart = c + 1; plen = 0;
            end
            ph = 0;
            if (fr) begin
                if (c < fs + TRIG_W)                ph = 1;
                else if (hs < 0)                    ph = 2;
                else if (ls < 0)                    ph = 3;
                else if (c <= ls + READ_CYCLES)     ph = 4;
                else                                ph = 5;
            end
            chk("trig_out",    int'(trig_out),    int'(ph == 1));
            chk("snap_stb",    int'(snap_stb),    int'(ph == 5));
            chk("state_o",     int'(state_o),     ph);
            chk("frame_valid", int'(frame_valid), fv);
            chk("frame_seq",   int'(frame_seq),   seq);
            chk("overrun_cnt", int'(overrun_cnt), ovr);
            chk("timeout_cnt", int'(timeout_cnt), tmo);
            chk("err_timeout", int'(err_timeout), eto);
            chk("err_lost",    int'(err_lost),    elo);
            if (!rst) begin
                tick = 0;
                if (enable) begin
                    off = c - pstart;
                    lim = (off == 0) ? int'(period) : plen;
                    if (lim < 1) lim = 1;
                    tick = (off == lim - 1);
                end
                s  = p2;
                fl = p3 && !p2;
                case (ph)
                    0: if (tick) begin fr = 1; fs = c + 1; hs = -1; ls = -1; end
                    2: begin
                        ws = fs + TRIG_W;
                        if (s) hs = c;
                        else if (c - ws == TIMEOUT - 1) begin
                            fr = 0; eto = 1; tmo = (tmo < 65535) ? tmo + 1 : tmo;
                        end
                    end
                    3: begin
                        ws = hs + 1;
                        if (fl) ls = c;
                        else if (c - ws == TIMEOUT - 1) begin
                            fr = 0; eto = 1; tmo = (tmo < 65535) ? tmo + 1 : tmo;
                        end
                    end
                    5: begin
                        seq = (seq + 1) % 65536;
                        if (fv == 1 && !frame_ack) elo = 1;
                        fv = 1;
                        fr = 0;
                    end
                    default: ;
                endcase
                if (ph != 0 && tick) ovr = (ovr < 65535) ? ovr + 1 : ovr;
                if (ph != 5 && frame_ack) fv = 0;
                if (clr_err) begin ovr = 0; tmo = 0; eto = 0; elo = 0; end
                if (!enable) pstart = c + 1;
                else begin
                    if (off == 0) plen = int'(period);
                    if (tick) pstart = c + 1;
                end
                p3 = p2; p2 = p1; p1 = busy;
            end
        end
    end

    task automatic wait_raw(input int which, input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget && t < 0; i++) begin
            @(negedge clk);
            if ((which == 0 && trig_out) || (which == 1 && snap_stb) || (which == 2 && err_timeout))
                t = cyc;
        end
    endtask

    task automatic wait_ev(input int which, input int budget, input string name, output int t);
        wait_raw(which, budget, t);
        total++;
        if (t < 0) begin
            bad++;
            $display("FAIL %s: event not seen, got none within %0d cycles", name, budget);
        end
    endtask

    task automatic ack_pulse();
        @(posedge clk); #1 frame_ack = 1'b1;
        @(posedge clk); #1 frame_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic clr_pulse();
        @(posedge clk); #1 clr_err = 1'b1;
        @(posedge clk); #1 clr_err = 1'b0;
        @(negedge clk);
    endtask

    initial begin : stim
        int t, t2, s, r;
        enable = 1'b1;
        period = 16'd200;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_state", int'(state_o), 0);
        chk("rst_trig", int'(trig_out), 0);
        @(posedge clk); #1 rst = 1'b0; r = cyc;

        // periodic run
        wait_ev(0, 400, "trig1", t);
        chk("first_trig_delay", t - r, 200);
        wait_ev(1, 200, "snap1", s);
        chk("snap_after_fall", s - fall_cyc, 37);
        chk("snap_after_trig", s - t, 87);
        ack_pulse();
        chk("fv_acked", int'(frame_valid), 0);
        wait_ev(0, 300, "trig2", t2);
        chk("trig_period", t2 - t, 200);
        wait_ev(1, 200, "snap2", s);
        ack_pulse();
        wait_ev(1, 300, "snap3", s);
        ack_pulse();
        chk("seq_after3", int'(frame_seq), 3);

        // timeout: busy never rises
        adc_on = 1'b0;
        wait_ev(0, 300, "trig_to", t);
        wait_ev(2, 1200, "err_to", s);
        chk("timeout_latency", s - t, TRIG_W + TIMEOUT);
        chk("timeout_cnt1", int'(timeout_cnt), 1);
        chk("timeout_idle", int'(state_o), 0);
        chk("ovr_during_to", int'(overrun_cnt), 5);
        chk("seq_no_publish", int'(frame_seq), 3);
        adc_on = 1'b1;
        wait_ev(0, 400, "trig_after_to", t2);
        chk("trig_after_to", t2 - t, 1200);
        wait_ev(1, 200, "snap4", s);
        ack_pulse();

        // clr_err
        clr_pulse();
        chk("clr_err_to", int'(err_timeout), 0);
        chk("clr_tmo_cnt", int'(timeout_cnt), 0);
        chk("clr_ovr_cnt", int'(overrun_cnt), 0);
        chk("clr_keeps_seq", int'(frame_seq), 4);

        // overrun, then two unacked frames
        period = 16'd50;
        wait_ev(0, 300, "trig_ov_a", t);
        wait_ev(1, 200, "snap_a", s);
        wait_ev(0, 200, "trig_ov_b", t2);
        chk("ovr_trig_spacing", t2 - t, 100);
        chk("ovr_one_drop", int'(overrun_cnt), 1);
        wait_ev(1, 200, "snap_b", s);
        @(negedge clk);
        chk("err_lost_set", int'(err_lost), 1);
        chk("fv_still_set", int'(frame_valid), 1);
        clr_pulse();
        chk("clr_err_lost", int'(err_lost), 0);
        chk("clr_keeps_fv", int'(frame_valid), 1);

        // ack in the publish cycle
        wait_ev(0, 100, "trig_c", t);
        repeat (87) @(posedge clk);
        #1 frame_ack = 1'b1;
        @(posedge clk); #1 frame_ack = 1'b0;
        @(negedge clk);
        chk("ack_pub_fv", int'(frame_valid), 1);
        chk("ack_pub_no_lost", int'(err_lost), 0);
        ack_pulse();

        // enable dropped during readout
        wait_ev(0, 200, "trig_d", t);
        repeat (60) @(posedge clk);
        #1 enable = 1'b0;
        wait_ev(1, 100, "snap_d", s);
        chk("snap_after_disable", s - t, 87);
        ack_pulse();
        wait_raw(0, 300, t2);
        chk("no_trig_disabled", t2, -1);

        // reset in WAIT_LO
        @(posedge clk); #1 enable = 1'b1;
        wait_ev(0, 100, "trig_e", t);
        repeat (30) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_state", int'(state_o), 0);
        chk("rst_mid_seq", int'(frame_seq), 0);
        chk("rst_mid_ovr", int'(overrun_cnt), 0);
        @(posedge clk); #1 rst = 1'b0; r = cyc;
        wait_ev(0, 100, "trig_rst", t2);
        chk("trig_after_rst", t2 - r, 50);
        wait_ev(1, 200, "snap_rst", s);
        ack_pulse();
        chk("seq_after_rst", int'(frame_seq), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish, want finish before 50000 cycles");
        $fatal(1);
    end

endmodule

// File: doc/enc_acq_scheduler.md
Name: enc_acq_scheduler

Overview:
- Sequences the 16-channel absolute-encoder ADC acquisition core. Generates the periodic conversion trigger that drives the core's clk_rd input.
- Supervises the ADC busy handshake with a timeout watchdog and decides when a readout frame is complete.
- Publishes a one-cycle snapshot strobe plus a valid/ack handshake toward the DSP side, with sequence number, overrun and error bookkeeping.

Parameters:
PERIOD_W, 16, width of the sample-period register, in clk cycles
TRIG_W, 4, trig_out high time in clk cycles (>=2)
READ_CYCLES, 34, clk cycles from busy falling edge to frame complete (32-cycle readout + 2 margin)
TIMEOUT, 1023, max clk cycles spent waiting for busy rise or busy fall
CNT_W, 16, width of the seq, overrun and timeout counters

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
enable  in  1  level; 1 = periodic acquisition running
period  in  PERIOD_W  sample period in clk cycles; sampled at each period wrap
busy  in  1  ADC busy pin, asynchronous, synchronised internally
clr_err  in  1  one-cycle pulse; clears sticky flags and counters
frame_ack  in  1  DSP acknowledges the published frame
trig_out  out  1  conversion trigger to the acquisition core's clk_rd
snap_stb  out  1  one-cycle pulse; latch the channel registers into the DSP-visible copy
frame_valid  out  1  a published frame is pending
frame_seq  out  CNT_W  count of published frames, wraps
overrun_cnt  out  CNT_W  period ticks lost because a frame was still in progress; saturates
timeout_cnt  out  CNT_W  aborted frames; saturates
err_timeout  out  1  sticky flag; a timeout has occurred
err_lost  out  1  sticky flag; a frame was published while frame_valid was still 1
state_o  out  3  current FSM state, for debug

Behaviour:
- Reset (async, rst=1): every output 0, FSM in IDLE, period counter 0, busy synchroniser 0.
- busy path:
  - Two-flop synchroniser, then one edge-detect register.
  - Edges are detected on the synchronised signal, so they are seen 3 cycles after the pin changes.
- Period counter:
  - Counts only while enable=1.
  - Wraps at period-1 and raises a tick in that cycle; period is reloaded at the wrap.
  - period=0 or period=1 both give a tick every cycle.
  - enable=0 clears the counter synchronously.
- FSM states: IDLE=0, TRIG=1, WAIT_HI=2, WAIT_LO=3, READ=4, PUBLISH=5.
  - IDLE: on tick, go to TRIG.
  - TRIG: trig_out=1 for exactly TRIG_W cycles, then go to WAIT_HI and clear the timeout counter.
  - WAIT_HI: on synced busy=1, go to WAIT_LO and clear the timeout counter.
  - WAIT_LO: on synced busy falling edge, go to READ and load the read counter with READ_CYCLES.
  - READ: decrement the counter; at 0, go to PUBLISH.
  - PUBLISH: one cycle only. Assert snap_stb, increment frame_seq, set frame_valid, return to IDLE.
- Timeout:
  - Applies in WAIT_HI and WAIT_LO. When the timeout counter reaches TIMEOUT, set err_timeout, increment timeout_cnt (saturating) and go to IDLE.
  - No snap_stb and no frame_seq increment for an aborted frame.
- Overrun:
  - A tick in any state other than IDLE is dropped and increments overrun_cnt (saturating).
  - A tick in the same cycle as PUBLISH also counts as an overrun.
- frame_valid handshake:
  - frame_valid is set in PUBLISH and cleared on frame_ack.
  - If PUBLISH occurs while frame_valid=1 and frame_ack=0: set err_lost; frame_valid stays 1.
  - If PUBLISH and frame_ack occur in the same cycle: frame_valid stays 1 and err_lost is not set.
  - frame_ack while frame_valid=0 is ignored.
- enable deassert mid-frame: the current frame finishes (or times out), then the FSM stays in IDLE. No new trigger is issued while enable=0.
- clr_err: clears err_timeout, err_lost, overrun_cnt and timeout_cnt. It does not clear frame_seq or frame_valid. A simultaneous increment event is lost; the clear wins.

Decomposition:
- Package enc_acq_pkg holds:
  - the state encoding enum (values fixed as listed);
  - the defaults for TRIG_W, READ_CYCLES and TIMEOUT;
  - a saturating-increment function.
- One sub-module: enc_busy_sync (2-flop synchroniser plus rise/fall pulse outputs), reused by other encoder blocks.

Test Plan:
- Reset and periodic run: enable=1, period=200, busy model rises 10 cycles after trig and falls 40 cycles later.
  - trig_out high exactly 4 cycles every 200 cycles.
  - snap_stb occurs 34+3 cycles after each busy fall.
  - frame_seq counts 1, 2, 3 ...
- Timeout: busy held 0 after trig.
  - After 1023 cycles in WAIT_HI: err_timeout=1, timeout_cnt=1, state back to IDLE, no snap_stb.
  - Next period triggers normally.
- Overrun: period=50 with a frame lasting ~80 cycles.
  - overrun_cnt increments once per dropped tick.
  - trig_out only pulses from IDLE.
- Handshake: never ack for two frames.
  - err_lost=1 after the second PUBLISH.
  - Ack in the same cycle as a PUBLISH: frame_valid stays 1 and err_lost stays 0.
- Enable drop and reset: drop enable during READ.
  - Frame still publishes, then no further trig.
  - rst asserted during WAIT_LO: all outputs 0 immediately; the first trig comes period cycles after rst release.
- clr_err: with err flags set and counters nonzero, a pulse clears them to 0. frame_seq is unchanged.
